syncnt_n: RTL and testbench



---
 rtl/syncnt_n_if.sv | 27 ++
 rtl/syncnt_n.sv | 60 ++++++
 tb/tb_syncnt_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/syncnt_n_if.sv
// Control/data/status bundle for one syncnt_n stage.
// The owner of the logical count clock drives the master side. The counter drives the slave side.
interface syncnt_n_if #(
   parameter int WIDTH = 4
) ();
   logic             CLK;
   logic [WIDTH-1:0] D;
   logic             LDL;
   logic             CLR;
   logic             CE;
   logic             UP;
   logic             RLD;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] QB;
   logic             TC;
   logic             CO;

   modport master (
      output CLK, D, LDL, CLR, CE, UP, RLD,
      input  Q, QB, TC, CO
   );

   modport slave (
      input  CLK, D, LDL, CLR, CE, UP, RLD,
      output Q, QB, TC, CO
   );
endinterface

// File: rtl/syncnt_n.sv
// Load/count/clear counter with up/down, auto-reload and cascade carry.
// It advances once per rising edge of the logical CLK strobe, and that edge is detected on MasterClock.
module syncnt_n #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic         MasterClock,
   input logic         Reset,
   syncnt_n_if.slave   bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             clk_d_reg;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] r_reg, r_next;
   logic             stb;
   logic             tc;

   // clk_d_reg resets high, so a CLK already high at release is not seen as an edge.
   always_ff @(posedge MasterClock or posedge Reset) begin
      if (Reset) begin
         clk_d_reg <= 1'b1;
         q_reg     <= RESET_VAL;
         r_reg     <= RESET_VAL;
      end else begin
         clk_d_reg <= bus.CLK;
         q_reg     <= q_next;
         r_reg     <= r_next;
      end
   end

   assign stb = bus.CLK & ~clk_d_reg;
   assign tc  = bus.UP ? (q_reg == '1) : (q_reg == '0);

   always_comb begin
      q_next = q_reg;
      r_next = r_reg;
      if (stb) begin
         if (bus.CLR) begin
            q_next = '0;
         end else if (!bus.LDL) begin
            q_next = bus.D;
            r_next = bus.D;
         end else if (bus.CE) begin
            // At the terminal count, reload replaces the wrap in both directions.
            if (tc && bus.RLD)
               q_next = r_reg;
            else if (bus.UP)
               q_next = q_reg + ONE;
            else
               q_next = q_reg - ONE;
         end
      end
   end

   assign bus.Q  = q_reg;
   assign bus.QB = ~q_reg;
   assign bus.TC = tc;
   assign bus.CO = tc & bus.CE;
endmodule

// File: tb/tb_syncnt_n.sv
// Bench for syncnt_n: directed scenarios plus random stimulus against an arithmetic reference model.
// Two 4-bit stages are cascaded, and the CO of stage 0 feeds the CE of stage 1.
module tb_syncnt_n;
   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic mc;
   logic rst;

   syncnt_n_if #(.WIDTH(W)) bus0 ();
   syncnt_n_if #(.WIDTH(W)) bus1 ();

   assign bus1.CLK = bus0.CLK;
   assign bus1.D   = bus0.D;
   assign bus1.LDL = bus0.LDL;
   assign bus1.CLR = bus0.CLR;
   assign bus1.UP  = bus0.UP;
   assign bus1.RLD = bus0.RLD;
   assign bus1.CE  = bus0.CO;

   syncnt_n #(.WIDTH(W), .RESET_VAL(4'h0)) u0 (.MasterClock(mc), .Reset(rst), .bus(bus0));
   syncnt_n #(.WIDTH(W), .RESET_VAL(4'h0)) u1 (.MasterClock(mc), .Reset(rst), .bus(bus1));

   initial mc = 1'b0;
   always #5 mc = ~mc;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int q_m[2];
   int r_m[2];
   bit clkd_m;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit tc_of(int q, bit up);
      return up ? (q == MASK) : (q == 0);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         q_m[s] = 0;
         r_m[s] = 0;
      end
      clkd_m = 1'b1;
   endtask

   task automatic model_step(int s, bit ce);
      if (bus0.CLR) begin
         q_m[s] = 0;
      end else if (!bus0.LDL) begin
         q_m[s] = int'(bus0.D);
         r_m[s] = int'(bus0.D);
      end else if (ce) begin
         if (tc_of(q_m[s], bus0.UP) && bus0.RLD)
            q_m[s] = r_m[s];
         else
            q_m[s] = (q_m[s] + (bus0.UP ? 1 : -1)) & MASK;
      end
   endtask

   task automatic check_outputs(string tag);
      bit tc0, tc1, co0;
      tc0 = tc_of(q_m[0], bus0.UP);
      tc1 = tc_of(q_m[1], bus0.UP);
      co0 = tc0 & bus0.CE;
      check({tag, ".q0"},  bus0.Q,  q_m[0]);
      check({tag, ".qb0"}, bus0.QB, (~q_m[0]) & MASK);
      check({tag, ".tc0"}, bus0.TC, tc0);
      check({tag, ".co0"}, bus0.CO, co0);
      check({tag, ".q1"},  bus1.Q,  q_m[1]);
      check({tag, ".qb1"}, bus1.QB, (~q_m[1]) & MASK);
      check({tag, ".tc1"}, bus1.TC, tc1);
      check({tag, ".co1"}, bus1.CO, tc1 & co0);
   endtask

   // One MasterClock cycle. The model samples the inputs at the edge, and the outputs are checked 1 time unit later.
   task automatic tick(string tag);
      bit stb, co0;
      @(posedge mc);
      if (rst) begin
         model_reset();
      end else begin
         stb    = bus0.CLK && !clkd_m;
         clkd_m = bus0.CLK;
         if (stb) begin
            co0 = tc_of(q_m[0], bus0.UP) && bus0.CE;
            model_step(0, bus0.CE);
            model_step(1, co0);
            $display("strobe %s: clr=%0b ldl=%0b d=%0h ce=%0b up=%0b rld=%0b -> q0=%0h q1=%0h",
                     tag, bus0.CLR, bus0.LDL, bus0.D, bus0.CE, bus0.UP, bus0.RLD, q_m[0], q_m[1]);
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic strobe(string tag);
      bus0.CLK = 1'b0;
      tick(tag);
      bus0.CLK = 1'b1;
      tick(tag);
   endtask

   task automatic set_ctl(bit clr, bit ldl, logic [W-1:0] d, bit ce, bit up, bit rld);
      bus0.CLR = clr;
      bus0.LDL = ldl;
      bus0.D   = d;
      bus0.CE  = ce;
      bus0.UP  = up;
      bus0.RLD = rld;
   endtask

   initial begin
      logic [W-1:0] up_seq[4];
      logic [W-1:0] dn_seq[5];
      up_seq = '{4'hD, 4'hE, 4'hF, 4'h0};
      dn_seq = '{4'h2, 4'h1, 4'h0, 4'h3, 4'h2};

      rst      = 1'b1;
      bus0.CLK = 1'b1;
      set_ctl(0, 1, 4'h0, 1, 1, 0);
      model_reset();

      // reset with CLK held high: no count after release
      tick("rst");
      tick("rst");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick("rst_hold");
      check("rst_q", bus0.Q, 4'h0);
      check("rst_qb", bus0.QB, 4'hF);

      // load C then count up through the wrap
      set_ctl(0, 0, 4'hC, 0, 1, 0);
      strobe("load_c");
      check("load_c", bus0.Q, 4'hC);
      set_ctl(0, 1, 4'h0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         strobe("up");
         check("up_q", bus0.Q, up_seq[i]);
         check("up_tc", bus0.TC, up_seq[i] == 4'hF);
         check("up_co", bus0.CO, up_seq[i] == 4'hF);
      end

      // down count with reload from 3
      set_ctl(0, 0, 4'h3, 0, 1, 0);
      strobe("load_3");
      set_ctl(0, 1, 4'h0, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         strobe("down_rld");
         check("dn_q", bus0.Q, dn_seq[i]);
         check("dn_tc", bus0.TC, dn_seq[i] == 4'h0);
      end

      // clear beats load and leaves R at 3
      set_ctl(1, 0, 4'h9, 1, 0, 1);
      strobe("prio");
      check("prio_q", bus0.Q, 4'h0);
      set_ctl(0, 1, 4'h0, 1, 0, 1);
      strobe("prio_rld");
      check("prio_rld", bus0.Q, 4'h3);

      // gating: CE low, and LDL low without a CLK edge
      set_ctl(0, 1, 4'h0, 0, 1, 0);
      for (int i = 0; i < 3; i++) strobe("ce_off");
      check("ce_off", bus0.Q, 4'h3);
      bus0.CLK = 1'b0;
      set_ctl(0, 0, 4'h5, 1, 1, 0);
      for (int i = 0; i < 3; i++) tick("no_edge");
      check("no_edge", bus0.Q, 4'h3);

      // cascade FF -> 00, with TC tracking UP immediately
      set_ctl(0, 0, 4'hF, 0, 1, 0);
      strobe("casc_load");
      bus0.LDL = 1'b1;
      bus0.UP  = 1'b0;
      #1;
      check("tc_dir_dn", bus0.TC, 1'b0);
      bus0.UP = 1'b1;
      #1;
      check("tc_dir_up", bus0.TC, 1'b1);
      bus0.CE = 1'b1;
      strobe("casc");
      check("casc_q0", bus0.Q, 4'h0);
      check("casc_q1", bus1.Q, 4'h0);

      // asynchronous reset in mid-cycle at Q=7
      set_ctl(0, 0, 4'h7, 0, 1, 0);
      strobe("load_7");
      check("load_7", bus0.Q, 4'h7);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_q0", bus0.Q, 4'h0);
      check("async_rst_q1", bus1.Q, 4'h0);
      set_ctl(0, 1, 4'h0, 1, 1, 0);
      tick("in_rst");
      tick("in_rst");
      rst = 1'b0;
      tick("post_rst");
      check("post_rst_hold", bus0.Q, 4'h0);
      strobe("post_rst");
      check("post_rst_cnt", bus0.Q, 4'h1);

      // random stimulus
      for (int i = 0; i < 600; i++) begin
         bus0.CLK = 1'($urandom_range(0, 1));
         bus0.D   = W'($urandom);
         bus0.LDL = ($urandom_range(0, 7) != 0);
         bus0.CLR = ($urandom_range(0, 15) == 0);
         bus0.CE  = ($urandom_range(0, 3) != 0);
         bus0.UP  = 1'($urandom_range(0, 1));
         bus0.RLD = 1'($urandom_range(0, 1));
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
